ref_block_fetch: RTL

- Consumes one generated sub-block motion vector (integer + 1/16 fractional parts, interpolation flags) per handshake.
- Emits the row-by-row reference-sample read requests the interpolation filter needs for one 4x4 sub-block, including the 8-tap filter margins when interpolating.
- Sits directly downstream of the motion-vector generator datapath and upstream of the reference line buffer / interpolation filter.

---
 rtl/ref_fetch_pkg.sv | 15 +
 rtl/row_clamp.sv | 21 ++
 rtl/ref_block_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ref_fetch_pkg.sv
// Shared types and constants for the reference block fetcher.
// Holds FSM state encoding and filter geometry.
package ref_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_FINISH = 2'd2
   } fetch_state_t;

   localparam int FILT_MARGIN = 3;
   localparam int FILT_EXT    = 7;
   localparam int ROW_CNT_W   = 4;

endpackage

// File: rtl/row_clamp.sv
// Saturates a signed 17-bit row index into [0, FRAME_H-1].
// Purely combinational.
module row_clamp #(
   parameter int FRAME_H = 1080,
   parameter int ROW_W   = 16
) (
   input  logic [16:0]      i_row,
   output logic [ROW_W-1:0] o_row
);

   always_comb begin
      o_row = '0;
      if (i_row[16])
         o_row = '0;
      else if (i_row >= 17'(FRAME_H))
         o_row = ROW_W'(FRAME_H - 1);
      else
         o_row = i_row[ROW_W-1:0];
   end

endmodule

// File: rtl/ref_block_fetch.sv
// Turns one sub-block motion vector into row read requests,
// widened by the filter margins when interpolating.
module ref_block_fetch
   import ref_fetch_pkg::*;
#(
   parameter int BLK_SIZE = 4,
   parameter int TAPS     = 8,
   parameter int FRAME_H  = 1080,
   parameter int ROW_W    = 16
) (
   input  logic             CLK,
   input  logic             RST_ASYNC_N,
   input  logic             MV_VALID,
   output logic             MV_READY,
   input  logic [14:0]      MV_X_INT,
   input  logic [14:0]      MV_Y_INT,
   input  logic [3:0]       MV_X_FRAC,
   input  logic [3:0]       MV_Y_FRAC,
   input  logic             INTERP_X,
   input  logic             INTERP_Y,
   input  logic [7:0]       BLK_X,
   input  logic [7:0]       BLK_Y,
   output logic             RD_EN,
   input  logic             RD_READY,
   output logic [ROW_W-1:0] RD_ROW,
   output logic [16:0]      RD_COL,
   output logic [3:0]       RD_LEN,
   output logic             RD_LAST,
   output logic [3:0]       FRAC_X,
   output logic [3:0]       FRAC_Y,
   output logic             DONE
);

   localparam logic [16:0] L_MARG = 17'(TAPS / 2 - 1);
   localparam logic [ROW_CNT_W-1:0] L_N_BLK = ROW_CNT_W'(BLK_SIZE);
   localparam logic [ROW_CNT_W-1:0] L_N_EXT = ROW_CNT_W'(BLK_SIZE + FILT_EXT);

   fetch_state_t r_state;
   fetch_state_t w_next;

   logic [ROW_CNT_W-1:0] r_cnt;
   logic [ROW_CNT_W-1:0] r_nrows;
   logic [16:0]          r_row0;
   logic [16:0]          r_col0;
   logic [3:0]           r_len;
   logic [3:0]           r_fx;
   logic [3:0]           r_fy;

   logic        w_accept;
   logic        w_xfer;
   logic [16:0] w_col0;
   logic [16:0] w_row0;
   logic [16:0] w_row;

   assign w_accept = MV_VALID & MV_READY;
   assign w_xfer   = RD_EN & RD_READY;

   // Unsigned origin plus sign-extended MV, minus the leading filter margin
   assign w_col0 = {9'b0, BLK_X} + {{2{MV_X_INT[14]}}, MV_X_INT}
                 - (INTERP_X ? L_MARG : 17'd0);
   assign w_row0 = {9'b0, BLK_Y} + {{2{MV_Y_INT[14]}}, MV_Y_INT}
                 - (INTERP_Y ? L_MARG : 17'd0);

   always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
      if (!RST_ASYNC_N)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      MV_READY = 1'b0;
      RD_EN    = 1'b0;
      RD_LAST  = 1'b0;
      DONE     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            MV_READY = 1'b1;
            if (MV_VALID)
               w_next = ST_FETCH;
         end
         ST_FETCH: begin
            RD_EN   = 1'b1;
            RD_LAST = (r_cnt == r_nrows - ROW_CNT_W'(1));
            if (RD_READY && RD_LAST)
               w_next = ST_FINISH;
         end
         ST_FINISH: begin
            DONE   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
      if (!RST_ASYNC_N) begin
         r_row0  <= '0;
         r_col0  <= '0;
         r_nrows <= '0;
         r_len   <= '0;
         r_fx    <= '0;
         r_fy    <= '0;
      end else if (w_accept) begin
         r_row0  <= w_row0;
         r_col0  <= w_col0;
         r_nrows <= INTERP_Y ? L_N_EXT : L_N_BLK;
         r_len   <= INTERP_X ? 4'(L_N_EXT) : 4'(L_N_BLK);
         r_fx    <= MV_X_FRAC;
         r_fy    <= MV_Y_FRAC;
      end
   end

   always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
      if (!RST_ASYNC_N)
         r_cnt <= '0;
      else if (r_state == ST_FINISH)
         r_cnt <= '0;
      else if (w_xfer)
         r_cnt <= r_cnt + ROW_CNT_W'(1);
   end

   assign w_row = r_row0 + {{(17 - ROW_CNT_W){1'b0}}, r_cnt};

   row_clamp #(
      .FRAME_H (FRAME_H),
      .ROW_W   (ROW_W)
   ) u_row_clamp (
      .i_row (w_row),
      .o_row (RD_ROW)
   );

   assign RD_COL = r_col0;
   assign RD_LEN = r_len;
   assign FRAC_X = r_fx;
   assign FRAC_Y = r_fy;

endmodule
